// File: rtl/trp_ctrl.sv
// trp_ctrl: accepts tile rows, fills an external transposer buffer, then drains transposed rows
// through a 2-entry output FIFO. Define TRP_CTRL_PERF_EN to add the perf_stall_cnt output.
module trp_ctrl #(
    parameter int BUFFD = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [BUFFD*8-1:0] in_data,
    output logic               ffinit,
    output logic               ffwreq,
    output logic               ffrreq,
    output logic [1:0]         ffmode,
    output logic [BUFFD*8-1:0] ffwdata,
    input  logic [BUFFD*8-1:0] ffrdata,
    input  logic               ffrvld,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [BUFFD*8-1:0] out_data,
    output logic               out_last,
    output logic               busy
`ifdef TRP_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int CW = $clog2(BUFFD) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(BUFFD);
    localparam logic [CW-1:0] QUAD_C = CW'(BUFFD / 4);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      wr_cnt_r;
    logic [CW-1:0]      rd_cnt_r;
    logic [CW-1:0]      out_idx_r;
    logic [CW-1:0]      rd_total_s;
    logic [1:0]         ffmode_r;
    logic [BUFFD*8-1:0] buf_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         occ_r;
    logic [1:0]         occ_left_s;
    logic               inflight_r;
    logic               in_rdy_s;
    logic               in_acc_s;
    logic               out_vld_s;
    logic               out_acc_s;
    logic               rd_req_s;
    logic               last_s;

    // Handshakes, read total and read-request credit check.
    always_comb begin
        in_rdy_s   = 1'b0;
        rd_total_s = FULL_C;
        rd_req_s   = 1'b0;
        if (reset_n && (state_r == ST_IDLE || state_r == ST_FILL)) begin
            in_rdy_s = 1'b1;
        end else begin
            in_rdy_s = 1'b0;
        end
        in_acc_s  = in_vld & in_rdy_s;
        out_vld_s = (occ_r != 2'd0);
        out_acc_s = out_vld_s & out_rdy;
        if (ffmode_r == 2'b10) begin
            rd_total_s = QUAD_C;
        end else begin
            rd_total_s = FULL_C;
        end
        // Count the slot freed by this cycle's pop so a stream at out_rdy=1 runs one beat per cycle.
        occ_left_s = occ_r - {1'b0, out_acc_s};
        if (state_r == ST_DRAIN && rd_cnt_r < rd_total_s &&
            (occ_left_s + {1'b0, inflight_r}) < 2'd2) begin
            rd_req_s = 1'b1;
        end else begin
            rd_req_s = 1'b0;
        end
        last_s = out_vld_s && (out_idx_r == rd_total_s - ONE_C);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_acc_s) state_nxt_s = ST_FILL;
                else          state_nxt_s = ST_IDLE;
            end
            ST_FILL: begin
                if (in_acc_s && wr_cnt_r == FULL_C - ONE_C) state_nxt_s = ST_DRAIN;
                else                                         state_nxt_s = ST_FILL;
            end
            ST_DRAIN: begin
                if (out_acc_s && last_s) state_nxt_s = ST_DONE;
                else                     state_nxt_s = ST_DRAIN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Tile counters, latched mode and in-flight read flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_r   <= '0;
            rd_cnt_r   <= '0;
            out_idx_r  <= '0;
            ffmode_r   <= 2'b01;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_req_s;
            case (state_r)
                ST_IDLE: begin
                    if (in_acc_s) begin
                        ffmode_r <= (mode == 2'b10) ? 2'b10 : 2'b01;
                        wr_cnt_r <= ONE_C;
                    end
                end
                ST_FILL: begin
                    if (in_acc_s) wr_cnt_r <= wr_cnt_r + ONE_C;
                end
                ST_DRAIN: begin
                    if (rd_req_s)  rd_cnt_r  <= rd_cnt_r + ONE_C;
                    if (out_acc_s) out_idx_r <= out_idx_r + ONE_C;
                end
                default: begin
                    wr_cnt_r  <= '0;
                    rd_cnt_r  <= '0;
                    out_idx_r <= '0;
                end
            endcase
        end
    end

    // Two-entry output FIFO fed by ffrvld.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_r[0] <= '0;
            buf_r[1] <= '0;
            wptr_r   <= 1'b0;
            rptr_r   <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (ffrvld) begin
                buf_r[wptr_r] <= ffrdata;
                wptr_r        <= ~wptr_r;
            end
            if (out_acc_s) rptr_r <= ~rptr_r;
            occ_r <= occ_r + {1'b0, ffrvld} - {1'b0, out_acc_s};
        end
    end

`ifdef TRP_CTRL_PERF_EN
    // Saturating count of downstream stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= 32'd0;
        end else if (out_vld_s && !out_rdy && perf_stall_cnt != 32'hFFFF_FFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

    assign in_rdy   = in_rdy_s;
    assign ffwreq   = in_acc_s;
    assign ffwdata  = in_data;
    assign ffrreq   = rd_req_s;
    assign ffinit   = (state_r == ST_DONE);
    assign ffmode   = ffmode_r;
    assign out_vld  = out_vld_s;
    assign out_data = buf_r[rptr_r];
    assign out_last = last_s;
    assign busy     = (state_r != ST_IDLE);

endmodule
